// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data memory request/response bus between mem_stage and the data memory
interface mem_stage_if;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  modport master (output d_req, d_we, d_addr, d_wdata, input d_ack, d_rdata);
  modport slave  (input d_req, d_we, d_addr, d_wdata, output d_ack, d_rdata);
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - pipeline memory stage: issues data memory accesses and registers writeback fields
module mem_stage (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  input  logic signed [31:0] res,
  input  logic signed [31:0] store_data,
  input  logic               load,
  input  logic               store,
  input  logic               enable_reg,
  input  logic signed [4:0]  Rd,
  input  logic [31:0]        pc_val,
  input  logic               link,
  input  logic               set,
  input  logic               condition,
  output logic               stall,
  mem_stage_if.master        dmem,
  output logic [31:0]        res_o,
  output logic [31:0]        d_data_read_s,
  output logic               read_word,
  output logic               enable_reg_o,
  output logic [4:0]         Rd_o,
  output logic [31:0]        pc_val_o,
  output logic               link_o,
  output logic               set_o,
  output logic               condition_o,
  output logic               align_err,
  output logic               timeout
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t      state, state_nxt;
  logic [3:0]  wait_cnt;
  logic [31:0] d_data_q;

  // Copy of the instruction held while the memory is slow to answer
  logic [31:0] l_res, l_wdata, l_pc;
  logic [4:0]  l_rd;
  logic        l_we, l_load, l_en, l_link, l_set, l_cond;

  logic        mem_op, aligned, complete, abort, go_access;

  // Field sources: live inputs in IDLE, the latched copy once waiting in ACCESS
  logic [31:0] src_res, src_pc;
  logic [4:0]  src_rd;
  logic        src_load, src_en, src_link, src_set, src_cond;

  assign mem_op  = in_valid & condition & (load | store);
  assign aligned = (res[1:0] == 2'b00);

  assign src_res  = (state == ACCESS) ? l_res  : res;
  assign src_pc   = (state == ACCESS) ? l_pc   : pc_val;
  assign src_rd   = (state == ACCESS) ? l_rd   : Rd;
  assign src_load = (state == ACCESS) ? l_load : load;
  assign src_en   = (state == ACCESS) ? l_en   : enable_reg;
  assign src_link = (state == ACCESS) ? l_link : link;
  assign src_set  = (state == ACCESS) ? l_set  : set;
  assign src_cond = (state == ACCESS) ? l_cond : condition;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state, memory request and stall; load wins when load and store are both set
  always_comb begin
    state_nxt     = state;
    dmem.d_req    = 1'b0;
    dmem.d_we     = 1'b0;
    dmem.d_addr   = res;
    dmem.d_wdata  = store_data;
    stall         = 1'b0;
    complete      = 1'b0;
    abort         = 1'b0;
    go_access     = 1'b0;
    if (state == IDLE) begin
      if (mem_op && aligned) begin
        dmem.d_req = reset_n;
        dmem.d_we  = reset_n & ~load;
        if (dmem.d_ack) begin
          complete = 1'b1;
        end else begin
          go_access = 1'b1;
          state_nxt = ACCESS;
        end
      end
    end else begin
      dmem.d_req   = 1'b1;
      dmem.d_we    = l_we;
      dmem.d_addr  = l_res;
      dmem.d_wdata = l_wdata;
      if (dmem.d_ack) begin
        complete  = 1'b1;
        state_nxt = IDLE;
      end else if (wait_cnt == 4'hF) begin
        abort     = 1'b1;
        state_nxt = IDLE;
      end else begin
        stall = 1'b1;
      end
    end
  end

  // Latched request copy, wait counter and the registered writeback fields
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt      <= '0;
      d_data_q      <= '0;
      l_res         <= '0;
      l_wdata       <= '0;
      l_pc          <= '0;
      l_rd          <= '0;
      l_we          <= 1'b0;
      l_load        <= 1'b0;
      l_en          <= 1'b0;
      l_link        <= 1'b0;
      l_set         <= 1'b0;
      l_cond        <= 1'b0;
      res_o         <= '0;
      d_data_read_s <= '0;
      read_word     <= 1'b0;
      enable_reg_o  <= 1'b0;
      Rd_o          <= '0;
      pc_val_o      <= '0;
      link_o        <= 1'b0;
      set_o         <= 1'b0;
      condition_o   <= 1'b0;
      align_err     <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      align_err <= 1'b0;
      timeout   <= 1'b0;

      // Load data trails read_word by one edge to line up with writeback's select
      if (read_word) d_data_read_s <= d_data_q;

      if (go_access) begin
        wait_cnt <= '0;
        l_res    <= res;
        l_wdata  <= store_data;
        l_pc     <= pc_val;
        l_rd     <= Rd;
        l_we     <= ~load;
        l_load   <= load;
        l_en     <= enable_reg;
        l_link   <= link;
        l_set    <= set;
        l_cond   <= condition;
      end else if (stall) begin
        wait_cnt <= wait_cnt + 4'd1;
      end

      if (complete || (state == IDLE && in_valid && !(mem_op && aligned))) begin
        res_o        <= src_res;
        Rd_o         <= src_rd;
        pc_val_o     <= src_pc;
        link_o       <= src_link;
        set_o        <= src_set;
        condition_o  <= src_cond;
        enable_reg_o <= src_en & ~(mem_op & ~aligned & (state == IDLE));
        read_word    <= complete & src_load;
        align_err    <= (state == IDLE) & mem_op & ~aligned;
        if (complete && src_load) d_data_q <= dmem.d_rdata;
      end else begin
        enable_reg_o <= 1'b0;
        read_word    <= 1'b0;
        link_o       <= 1'b0;
        set_o        <= 1'b0;
        condition_o  <= 1'b0;
        timeout      <= abort;
      end
    end
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have ports: clk in 1 clock; reset_n in 1, asynchronous, active-low reset.
REQ-002 The block SHALL have execute-side inputs: in_valid 1; res 32 signed (ALU result / address); store_data 32 signed; load 1; store 1; enable_reg 1; Rd 5 signed; pc_val 32; link 1; set 1; condition 1.
REQ-003 The block SHALL have stall out 1: execute must hold its inputs while high.
REQ-004 The block SHALL have data-memory ports: d_req out 1; d_we out 1; d_addr out 32; d_wdata out 32; d_ack in 1; d_rdata in 32.
REQ-005 The block SHALL have writeback-side outputs, all registered: res_o 32; d_data_read_s 32; read_word 1; enable_reg_o 1; Rd_o 5; pc_val_o 32; link_o 1; set_o 1; condition_o 1.
REQ-006 The block SHALL have status outputs: align_err 1 pulse; timeout 1 pulse.

Function
REQ-007 The block SHALL use a two-state FSM: IDLE, ACCESS.
REQ-008 An instruction is a memory op when in_valid=1, condition=1 and (load|store)=1; load=store=1 SHALL be treated as load.
REQ-009 Non-memory op or condition=0 in IDLE: SHALL issue no request; fields SHALL forward to outputs at the next edge (1-cycle latency), read_word=0.
REQ-010 Memory op in IDLE with res[1:0]=0: d_req=1 combinationally that cycle; d_addr=res, d_we=store, d_wdata=store_data.
REQ-011 If d_ack=1 in the request cycle, the op SHALL complete at that edge; stall=0.
REQ-012 If d_ack=0 in the request cycle, FSM SHALL enter ACCESS; in ACCESS, stall=1 and d_req/d_we/d_addr/d_wdata SHALL be held from latched copies.
REQ-013 In ACCESS, d_ack=1 SHALL complete the op at that edge; FSM returns to IDLE; stall=0 in that cycle.
REQ-014 On load completion: read_word=1 and d_rdata captured into internal d_data_q; d_data_read_s SHALL load d_data_q one edge later (lags read_word by one cycle, aligned with writeback's registered select).
REQ-015 d_data_read_s SHALL hold its value until the next load completion propagates.
REQ-016 On store completion: read_word=0, other fields forwarded unchanged.
REQ-017 While stall=1 (not completing), outputs SHALL carry a bubble: enable_reg_o=0, read_word=0, link_o=0, set_o=0, condition_o=0; other outputs hold.
REQ-018 Misaligned memory op (res[1:0]!=0): no request; align_err pulses 1 cycle at next edge; instruction forwarded with enable_reg_o=0, read_word=0.
REQ-019 A 4-bit wait counter SHALL clear on entering ACCESS and increment each ACCESS cycle without ack; at count 15 without ack, op aborts: timeout pulses 1 cycle, FSM to IDLE, output bubble as REQ-017, stall=0.
REQ-020 d_ack while FSM is IDLE with no request SHALL be ignored.
REQ-021 in_valid=0 SHALL produce a bubble as REQ-017.

Reset
REQ-022 On reset_n=0, asynchronously: FSM=IDLE, counter=0, all registered outputs and d_data_q=0; d_req=0, stall=0, align_err=0, timeout=0.
REQ-023 Reset asserted during ACCESS SHALL abandon the access with no output pulse; a late d_ack after reset release SHALL be ignored (REQ-020).

Verification
REQ-024 ALU op res=0x12, Rd=3, enable_reg=1, no mem -> next cycle res_o=0x12, Rd_o=3, enable_reg_o=1, read_word=0, no d_req.
REQ-025 Load res=0x100, d_ack same cycle, d_rdata=0xCAFEBABE -> next cycle read_word=1; cycle after d_data_read_s=0xCAFEBABE; stall never high.
REQ-026 Store res=0x200, data 0x55, ack after 3 wait cycles -> stall=1 for 3 cycles, d_addr/d_wdata stable, bubbles out, then forwarded with read_word=0.
REQ-027 Load res=0x103 -> no d_req, align_err one pulse, enable_reg_o=0.
REQ-028 Load, d_ack never -> stall 15 cycles, timeout one pulse, stall=0, bubble out.
REQ-029 Reset mid-ACCESS then d_ack 2 cycles later -> all outputs 0, no read_word, FSM IDLE.
